// File: rtl/mode_counter_if.sv
// Bus bundle for mode_counter: count enable, mode select, table write port
// and the counter status outputs.
interface mode_counter_if #(
  parameter int WIDTH  = 5,
  parameter int MODE_W = 3
);
  logic              en;
  logic [MODE_W-1:0] mode;
  logic              cfg_we;
  logic [MODE_W-1:0] cfg_mode;
  logic [WIDTH-1:0]  cfg_max;
  logic [WIDTH-1:0]  count;
  logic [WIDTH-1:0]  max_num;
  logic              wrap;
  logic              mode_chg;
  logic              active;

  modport master (
    output en, mode, cfg_we, cfg_mode, cfg_max,
    input  count, max_num, wrap, mode_chg, active
  );

  modport slave (
    input  en, mode, cfg_we, cfg_mode, cfg_max,
    output count, max_num, wrap, mode_chg, active
  );
endinterface

// File: rtl/mode_counter.sv
// Modulo counter whose terminal value comes from a writable per-mode table;
// a mode change restarts the count and pulses mode_chg, rollover pulses wrap.
module mode_counter #(
  parameter int WIDTH  = 5,
  parameter int MODE_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mode_counter_if.slave bus
);
  localparam int DEPTH = 1 << MODE_W;

  logic [WIDTH-1:0]  r_table [DEPTH];
  logic [MODE_W-1:0] r_mode_q;
  logic [WIDTH-1:0]  r_count;
  logic              r_wrap;
  logic              r_mode_chg;
  logic [WIDTH-1:0]  w_max_num;
  logic              w_active;

  // Power-on table contents; values wider than WIDTH keep only their low bits.
  function automatic logic [WIDTH-1:0] default_entry(input int idx);
    int v;
    case (idx)
      1:       v = 32'sd6;
      3:       v = 32'sd11;
      4:       v = 32'sd5;
      5:       v = 32'sd16;
      default: v = 32'sd0;
    endcase
    return v[WIDTH-1:0];
  endfunction

  assign w_max_num = r_table[r_mode_q];
  assign w_active  = (w_max_num != {WIDTH{1'b0}});

  // Table writes plus the mode/count state machine, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= default_entry(i);
      end
      r_mode_q   <= {MODE_W{1'b0}};
      r_count    <= {WIDTH{1'b0}};
      r_wrap     <= 1'b0;
      r_mode_chg <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        r_table[bus.cfg_mode] <= bus.cfg_max;
      end else begin
        r_table[bus.cfg_mode] <= r_table[bus.cfg_mode];
      end
      // The evaluation below sees the pre-write entry through w_max_num.
      if (bus.mode != r_mode_q) begin
        r_mode_q   <= bus.mode;
        r_count    <= {WIDTH{1'b0}};
        r_wrap     <= 1'b0;
        r_mode_chg <= 1'b1;
      end else if (!w_active) begin
        r_count    <= {WIDTH{1'b0}};
        r_wrap     <= 1'b0;
        r_mode_chg <= 1'b0;
      end else if (bus.en) begin
        if (r_count >= w_max_num) begin
          r_count <= {WIDTH{1'b0}};
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count + WIDTH'(1);
          r_wrap  <= 1'b0;
        end
        r_mode_chg <= 1'b0;
      end else begin
        r_wrap     <= 1'b0;
        r_mode_chg <= 1'b0;
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.wrap     = r_wrap;
  assign bus.mode_chg = r_mode_chg;
  assign bus.max_num  = w_max_num;
  assign bus.active   = w_active;
endmodule

// File: tb/tb_mode_counter.sv
// Directed scenarios then random traffic, checked against a behavioural model
// of the table, the mode register and the counter.
module tb_mode_counter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  int m_tbl [8];
  int m_mode, m_cnt, m_wrap, m_chg;

  mode_counter_if #(.WIDTH(5), .MODE_W(3)) bus ();
  mode_counter #(.WIDTH(5), .MODE_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = 0;
    m_tbl[1] = 6; m_tbl[3] = 11; m_tbl[4] = 5; m_tbl[5] = 16;
    m_mode = 0; m_cnt = 0; m_wrap = 0; m_chg = 0;
  endtask

  // Advance the model by one edge from the current inputs, clock, then compare.
  task automatic tick();
    int old_max;
    if (!rst_n) begin
      model_reset();
    end else begin
      old_max = m_tbl[m_mode];
      if (bus.cfg_we) m_tbl[bus.cfg_mode] = bus.cfg_max;
      if (int'(bus.mode) != m_mode) begin
        m_mode = bus.mode; m_cnt = 0; m_wrap = 0; m_chg = 1;
      end else if (old_max == 0) begin
        m_cnt = 0; m_wrap = 0; m_chg = 0;
      end else if (bus.en) begin
        m_chg = 0;
        if (m_cnt >= old_max) begin m_cnt = 0; m_wrap = 1; end
        else begin m_cnt = m_cnt + 1; m_wrap = 0; end
      end else begin
        m_wrap = 0; m_chg = 0;
      end
    end
    @(posedge clk);
    #1;
    check("count", bus.count, m_cnt);
    check("wrap", bus.wrap, m_wrap);
    check("mode_chg", bus.mode_chg, m_chg);
    check("max_num", bus.max_num, m_tbl[m_mode]);
    check("active", bus.active, (m_tbl[m_mode] != 0) ? 1 : 0);
    check("wrap_and_chg", bus.wrap & bus.mode_chg, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int nw;
    model_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 3'd0; bus.cfg_we = 1'b0;
    bus.cfg_mode = 3'd0; bus.cfg_max = 5'd0;
    ticks(2);
    check("rst_count", bus.count, 0);
    check("rst_active", bus.active, 0);

    // Release with mode 1: period of 7 enabled cycles.
    rst_n = 1'b1; bus.mode = 3'd1; bus.en = 1'b1;
    tick();
    check("m1_chg", bus.mode_chg, 1);
    check("m1_max", bus.max_num, 6);
    nw = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 5) check("m1_top", bus.count, 6);
      nw += int'(bus.wrap);
    end
    check("m1_wraps", nw, 2);

    // Disabled modes never count.
    bus.mode = 3'd0; ticks(20);
    bus.mode = 3'd2; ticks(20);
    check("m2_count", bus.count, 0);
    check("m2_active", bus.active, 0);

    // Mode 5 at count 9 switched to mode 4.
    bus.mode = 3'd5; tick(); ticks(9);
    check("m5_count9", bus.count, 9);
    bus.mode = 3'd4; tick();
    check("m4_count", bus.count, 0);
    check("m4_chg", bus.mode_chg, 1);
    check("m4_max", bus.max_num, 5);
    ticks(5);
    check("m4_top", bus.count, 5);
    tick();
    check("m4_wrap", bus.wrap, 1);

    // Raise the mode-3 maximum while running.
    bus.mode = 3'd3; tick(); ticks(7);
    check("m3_count7", bus.count, 7);
    bus.cfg_we = 1'b1; bus.cfg_mode = 3'd3; bus.cfg_max = 5'd20; tick();
    bus.cfg_we = 1'b0;
    check("m3_no_reset", bus.count, 8);
    ticks(12);
    check("m3_top", bus.count, 20);
    tick();
    check("m3_wrap", bus.wrap, 1);

    // Lower the mode-1 maximum below the running count.
    bus.mode = 3'd1; tick(); ticks(5);
    check("m1_count5", bus.count, 5);
    bus.en = 1'b0; bus.cfg_we = 1'b1; bus.cfg_mode = 3'd1; bus.cfg_max = 5'd2; tick();
    bus.cfg_we = 1'b0; bus.en = 1'b1; tick();
    check("m1_low_count", bus.count, 0);
    check("m1_low_wrap", bus.wrap, 1);
    ticks(3);
    check("m1_period3", bus.wrap, 1);

    // Hold, then reset after a table write restores defaults.
    bus.mode = 3'd3; tick(); ticks(4);
    bus.en = 1'b0; ticks(5);
    check("hold4", bus.count, 4);
    bus.cfg_we = 1'b1; bus.cfg_mode = 3'd1; bus.cfg_max = 5'd9; tick();
    bus.cfg_we = 1'b0; rst_n = 1'b0; tick();
    check("rst2_count", bus.count, 0);
    rst_n = 1'b1; bus.mode = 3'd1; tick();
    check("rst2_max", bus.max_num, 6);

    for (int k = 0; k < 1500; k++) begin
      rst_n = ($urandom_range(99) != 0);
      if ($urandom_range(11) == 0) bus.mode = 3'($urandom_range(7));
      bus.en       = ($urandom_range(4) != 0);
      bus.cfg_we   = ($urandom_range(9) == 0);
      bus.cfg_mode = 3'($urandom_range(7));
      bus.cfg_max  = 5'($urandom_range(31));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5: bit width of the counter and of every maximum-value entry.
REQ-002 The block SHALL have parameter MODE_W, default 3: bit width of the mode selector; table depth is 2**MODE_W entries.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port mode, input, MODE_W: requested operating mode.
REQ-007 Port cfg_we, input, 1: table write strobe.
REQ-008 Port cfg_mode, input, MODE_W: table entry addressed by a write.
REQ-009 Port cfg_max, input, WIDTH: value written to the entry.
REQ-010 Port count, output, WIDTH: current count value.
REQ-011 Port max_num, output, WIDTH: table entry of the registered mode (mode_q), combinational from mode_q and the table.
REQ-012 Port wrap, output, 1: registered one-cycle pulse on each terminal-count rollover.
REQ-013 Port mode_chg, output, 1: registered one-cycle pulse when a new mode is accepted.
REQ-014 Port active, output, 1: high when max_num != 0.

Function
REQ-015 The block SHALL hold a register mode_q (MODE_W) and a writable table of 2**MODE_W entries of WIDTH bits.
REQ-016 Table reset contents SHALL be: entry 1 = 6, entry 3 = 11, entry 4 = 5, entry 5 = 16, all other entries = 0; any default that does not fit in WIDTH SHALL truncate to WIDTH bits.
REQ-017 Per-cycle priority SHALL be: reset, then mode change, then counting.
REQ-018 Mode change: if mode != mode_q at a clock edge, then mode_q <= mode, count <= 0, mode_chg <= 1 and wrap <= 0, regardless of en.
REQ-019 Mode change latency SHALL be one cycle: max_num, active and mode_chg reflect the new mode in the cycle after mode changes.
REQ-020 Counting: with no mode change, en = 1 and active = 1, if count >= max_num then count <= 0 and wrap <= 1; otherwise count <= count + 1 and wrap <= 0.
REQ-021 The comparison SHALL be >= so that a count left above a newly lowered maximum wraps on the next enabled cycle.
REQ-022 With en = 0 and no mode change, count SHALL hold and wrap and mode_chg SHALL be 0.
REQ-023 Disabled mode (max_num = 0): count SHALL be held at 0, wrap SHALL never assert, and active SHALL be 0.
REQ-024 A count sequence SHALL have period max_num + 1 enabled cycles: 0..max_num.
REQ-025 Table write: when cfg_we = 1, table[cfg_mode] <= cfg_max at the edge; the new value governs counting from the following cycle.
REQ-026 A table write SHALL NOT reset count or pulse mode_chg, even when cfg_mode == mode_q.
REQ-027 When a table write and a count evaluation occur in the same cycle, the evaluation SHALL use the old entry value.
REQ-028 mode_chg and wrap SHALL never be high in the same cycle.

Reset
REQ-029 While rst_n = 0 at an edge, the block SHALL set count = 0, mode_q = 0, wrap = 0 and mode_chg = 0, restore the default table, and ignore cfg_we, en and mode.
REQ-030 After reset, max_num = 0 and active = 0.
REQ-031 If mode != 0 at reset release, the first post-reset edge SHALL perform a mode change (mode_chg = 1).
REQ-032 Reset asserted mid-count or after table writes SHALL restore all defaults in one edge.

Verification
REQ-033 Reset release with mode = 1, en = 1 -> next cycle mode_chg = 1, count = 0, max_num = 6; count then runs 1..6, returns to 0 with wrap = 1, and repeats every 7 cycles.
REQ-034 Mode = 0, then mode = 2, en = 1 for 20 cycles each -> count = 0, active = 0, wrap = 0 throughout.
REQ-035 Mode 5 running at count = 9, mode switched to 4 -> next cycle count = 0, mode_chg = 1, max_num = 5; wrap follows at count 5.
REQ-036 In mode 3 at count = 7, write cfg_mode = 3, cfg_max = 20 -> no count reset; count continues to 20, then wraps to 0 with wrap = 1.
REQ-037 In mode 1 at count = 5, write cfg_mode = 1, cfg_max = 2 -> next enabled cycle count = 0 with wrap = 1; period becomes 3.
REQ-038 Hold en = 0 at count = 4 for 5 cycles -> count stays 4; then assert rst_n = 0 after a table write -> count = 0, table entry 1 reads back 6 via max_num once mode = 1 is reapplied.
